// File: rtl/bit_reverse_unscramble_pkg.sv
// rtl/bit_reverse_unscramble_pkg.sv - shared sizes and the 9-bit index reversal
package bit_reverse_unscramble_pkg;

    localparam int DATA_SIZE_ARB = 32;
    localparam int PE_NUMBER     = 32;
    localparam int DEPTH         = 16;
    localparam int LOG_N         = 9;
    localparam int N             = PE_NUMBER * DEPTH;
    localparam int LANE_W        = $clog2(PE_NUMBER);
    localparam int ROW_W         = $clog2(DEPTH);
    localparam int BUS_W         = DATA_SIZE_ARB * PE_NUMBER;

    function automatic logic [LOG_N-1:0] bitrev9(input logic [LOG_N-1:0] j);
        logic [LOG_N-1:0] r;
        for (int k = 0; k < LOG_N; k++) begin
            r[k] = j[LOG_N-1-k];
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_reverse_unscramble_reorder_frame_buf.sv
// rtl/bit_reverse_unscramble_reorder_frame_buf.sv - one frame of storage, scattered write, natural-row read
module reorder_frame_buf
    import bit_reverse_unscramble_pkg::*;
(
    input  logic             clk,
    input  logic             we_i,
    input  logic [ROW_W-1:0] wr_row_i,
    input  logic [BUS_W-1:0] wr_data_i,
    input  logic [ROW_W-1:0] rd_row_i,
    output logic [BUS_W-1:0] rd_data_o
);

    logic [DATA_SIZE_ARB-1:0] mem_q [N];

    // Storage carries no reset; the full flags in the parent decide what is valid.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int l = 0; l < PE_NUMBER; l++) begin
                mem_q[bitrev9({wr_row_i, l[LANE_W-1:0]})] <= wr_data_i[DATA_SIZE_ARB*l +: DATA_SIZE_ARB];
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int l = 0; l < PE_NUMBER; l++) begin
            rd_data_o[DATA_SIZE_ARB*l +: DATA_SIZE_ARB] = mem_q[{rd_row_i, l[LANE_W-1:0]}];
        end
    end

endmodule

// File: rtl/bit_reverse_unscramble.sv
// rtl/bit_reverse_unscramble.sv - ping-pong bit-reversed to natural-order frame reorder
module bit_reverse_unscramble
    import bit_reverse_unscramble_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BUS_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BUS_W-1:0] out_data,
    output logic             out_last
);

    logic [ROW_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [ROW_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic [1:0]       full_q, full_d;
    logic             wr_fire, rd_fire;
    logic [BUS_W-1:0] rd_row [2];

    for (genvar b = 0; b < 2; b++) begin : g_buf
        reorder_frame_buf u_buf (
            .clk       (clk),
            .we_i      (wr_fire && (wr_sel_q == 1'(b))),
            .wr_row_i  (wr_cnt_q),
            .wr_data_i (in_data),
            .rd_row_i  (rd_cnt_q),
            .rd_data_o (rd_row[b])
        );
    end

    always_comb begin
        in_ready  = !full_q[wr_sel_q] && !clear;
        out_valid = full_q[rd_sel_q];
        out_last  = out_valid && (rd_cnt_q == ROW_W'(DEPTH - 1));
        out_data  = out_valid ? rd_row[rd_sel_q] : '0;
        wr_fire   = in_valid && in_ready;
        rd_fire   = out_valid && out_ready && !clear;
    end

    // A write and a read completing together always target different buffers.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        full_d   = full_q;
        if (clear) begin
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            wr_sel_d = 1'b0;
            rd_sel_d = 1'b0;
            full_d   = '0;
        end else begin
            if (wr_fire) begin
                wr_cnt_d = wr_cnt_q + 1'b1;
                if (wr_cnt_q == ROW_W'(DEPTH - 1)) begin
                    full_d[wr_sel_q] = 1'b1;
                    wr_sel_d         = ~wr_sel_q;
                end
            end
            if (rd_fire) begin
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (rd_cnt_q == ROW_W'(DEPTH - 1)) begin
                    full_d[rd_sel_q] = 1'b0;
                    rd_sel_d         = ~rd_sel_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            full_q   <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            full_q   <= full_d;
        end
    end

endmodule

// File: tb/tb_bit_reverse_unscramble.sv
// tb/tb_bit_reverse_unscramble.sv - directed self-checking bench for bit_reverse_unscramble
module tb_bit_reverse_unscramble;
    import bit_reverse_unscramble_pkg::*;

    logic             clk = 1'b0;
    logic             reset_n, clear, in_valid, in_ready, out_valid, out_ready, out_last;
    logic [BUS_W-1:0] in_data, out_data;

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [BUS_W-1:0] exp_q [$];
    logic [BUS_W-1:0] cap [16];
    int               out_cnt   = 0;
    int               beat_idx  = 0;
    int               stall_cnt = 0;
    logic             in_fire, out_fire, s_in_ready, s_out_valid;
    int               c0, acc, bad;
    logic [BUS_W-1:0] held;

    always #5 clk = ~clk;

    bit_reverse_unscramble dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    function automatic int tb_bitrev9(input int j);
        int r = 0;
        for (int k = 0; k < 9; k++) begin
            if (((j >> k) & 1) != 0) r = r | (1 << (8 - k));
        end
        return r;
    endfunction

    function automatic logic [BUS_W-1:0] frame_beat(input int tag, input int b);
        logic [BUS_W-1:0] v;
        for (int l = 0; l < PE_NUMBER; l++) v[DATA_SIZE_ARB*l +: DATA_SIZE_ARB] = 32'(tag + tb_bitrev9(32*b + l));
        return v;
    endfunction

    task automatic push_frame(input int tag);
        logic [BUS_W-1:0] v;
        for (int r = 0; r < DEPTH; r++) begin
            for (int l = 0; l < PE_NUMBER; l++) v[DATA_SIZE_ARB*l +: DATA_SIZE_ARB] = 32'(tag + 32*r + l);
            exp_q.push_back(v);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
        int fl = 0;
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            for (int l = PE_NUMBER - 1; l >= 0; l--)
                if (obs[DATA_SIZE_ARB*l +: DATA_SIZE_ARB] !== exp[DATA_SIZE_ARB*l +: DATA_SIZE_ARB]) fl = l;
            $error("FAIL %s lane %0d: observed %0d expected %0d", tag, fl,
                   obs[DATA_SIZE_ARB*fl +: DATA_SIZE_ARB], exp[DATA_SIZE_ARB*fl +: DATA_SIZE_ARB]);
        end
    endtask

    // Called at a falling edge with inputs already driven; samples, scores, and advances one cycle.
    task automatic tick();
        #1;
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        in_fire     = in_valid && in_ready;
        out_fire    = out_valid && out_ready;
        if (in_valid && !in_ready) stall_cnt++;
        if (out_fire) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_beat", 32'(out_fire), 32'd0);
            end else begin
                check_beat("out_data", out_data, exp_q.pop_front());
                check("out_last", 32'(out_last), 32'(beat_idx == 15));
            end
            cap[beat_idx] = out_data;
            beat_idx = (beat_idx + 1) % 16;
            out_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_frames(input int nf, input int tag0, input int tag_step, input int pin, input int pout);
        int sent = 0;
        int cyc  = 0;
        while ((sent < nf * 16 || exp_q.size() > 0) && cyc < 8000) begin
            in_valid  = (sent < nf * 16) && ($urandom_range(99) < pin);
            in_data   = frame_beat(tag0 + (sent / 16) * tag_step, sent % 16);
            out_ready = ($urandom_range(99) < pout);
            tick();
            if (in_fire) begin
                sent++;
                if (sent % 16 == 0) push_frame(tag0 + (sent / 16 - 1) * tag_step);
            end
            cyc++;
        end
        check("cycle_budget", 32'(cyc < 8000), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        @(negedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check_beat("rst_out_data", out_data, '0);
        @(negedge clk);
        reset_n = 1'b1;

        // single tagged frame, latency and spot values
        for (int b = 0; b < 16; b++) begin
            in_valid = 1'b1; in_data = frame_beat(0, b); out_ready = 1'b1;
            tick();
        end
        check("latency_pre", 32'(s_out_valid), 32'd0);
        push_frame(0);
        in_valid = 1'b0;
        tick();
        check("latency_first", 32'(s_out_valid), 32'd1);
        repeat (15) tick();
        tick();
        check("drained_out_valid", 32'(s_out_valid), 32'd0);
        check("spot_b8_l0", cap[8][31:0], 32'd256);
        check("spot_b0_l1", cap[0][63:32], 32'd1);
        check("frame1_count", 32'(out_cnt), 32'd16);

        // back-to-back frames at full rate
        stall_cnt = 0; c0 = out_cnt;
        run_frames(3, 0, 1000, 100, 100);
        check("b2b_no_stall", 32'(stall_cnt), 32'd0);
        check("b2b_count", 32'(out_cnt - c0), 32'd48);

        // both buffers full under backpressure
        out_ready = 1'b0; in_valid = 1'b1; acc = 0;
        for (int b = 0; b < 32; b++) begin
            in_data = frame_beat(20000 + (b / 16) * 1000, b % 16);
            tick();
            if (in_fire) acc++;
        end
        check("bp_accepted", 32'(acc), 32'd32);
        push_frame(20000); push_frame(21000);
        in_data = frame_beat(99000, 0);
        tick();
        check("bp_in_ready_low", 32'(s_in_ready), 32'd0);
        in_valid = 1'b0;
        held = exp_q[0];
        for (int i = 0; i < 3; i++) begin
            tick();
            check_beat("bp_stable_data", out_data, held);
            check("bp_stable_last", 32'(out_last), 32'd0);
        end
        out_ready = 1'b1; bad = 0;
        for (int r = 0; r < 16; r++) begin
            tick();
            if (s_in_ready) bad++;
        end
        check("bp_in_ready_during_drain", 32'(bad), 32'd0);
        tick();
        check("bp_in_ready_return", 32'(s_in_ready), 32'd1);
        repeat (15) tick();
        check("bp_all_drained", 32'(exp_q.size()), 32'd0);
        out_ready = 1'b0;

        // random stalls
        c0 = out_cnt;
        run_frames(20, 5000, 1000, 50, 50);
        check("rand_count", 32'(out_cnt - c0), 32'd320);

        // clear after 7 beats, then a fresh frame
        in_valid = 1'b1; out_ready = 1'b1;
        for (int b = 0; b < 7; b++) begin
            in_data = frame_beat(90000, b);
            tick();
        end
        clear = 1'b1; in_data = frame_beat(90000, 7);
        tick();
        check("clear_in_ready", 32'(s_in_ready), 32'd0);
        clear = 1'b0; in_valid = 1'b0;
        tick();
        c0 = out_cnt;
        run_frames(1, 7000, 0, 100, 100);
        check("clear_count", 32'(out_cnt - c0), 32'd16);

        // async reset during output beat 5
        out_ready = 1'b0; in_valid = 1'b1;
        for (int b = 0; b < 16; b++) begin
            in_data = frame_beat(3000, b);
            tick();
        end
        push_frame(3000);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check_beat("arst_out_data", out_data, '0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        beat_idx = 0; out_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        c0 = out_cnt;
        run_frames(1, 4000, 0, 100, 100);
        check("arst_next_count", 32'(out_cnt - c0), 32'd16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_reverse_unscramble.md
Name: bit_reverse_unscramble

Overview:
- Receives one 512-coefficient polynomial as 16 beats of PE_NUMBER lanes, in bit-reversed order, as the NTT datapath emits it.
- Returns the same frame in natural order on a ready/valid stream.
- Inverse-direction companion of the bit-reversal scatter stage; sits between the PE array output and the polynomial store / host readback.
- Double-buffered (ping-pong) so one frame can be written while the previous frame drains.

Parameters:
- DATA_SIZE_ARB, 32, coefficient width in bits.
- PE_NUMBER, 32, lanes per beat.
- DEPTH, 16, beats per frame.
- LOG_N, 9, log2(PE_NUMBER*DEPTH). Frame size N = 512.

Ports:
- clk  input  1  single clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort: discards both buffers and any partial frame.
- in_valid  input  1  input beat valid.
- in_ready  output  1  module can accept an input beat.
- in_data  input  DATA_SIZE_ARB*PE_NUMBER  lane l at bits [DATA_SIZE_ARB*l +: DATA_SIZE_ARB].
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the output beat.
- out_data  output  DATA_SIZE_ARB*PE_NUMBER  natural-order beat, same lane packing as in_data.
- out_last  output  1  high with out_valid on output beat 15.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset state: in_ready=1, out_valid=0, out_last=0, out_data=0. Write/read counters, wr_sel, rd_sel and full[1:0] all 0. Storage is not reset.
- Mapping:
  - Input beat b, lane l carries X[bitrev9(32*b+l)].
  - Output beat r, lane l carries X[32*r+l].
  - Equivalent write rule: input word at index j=32b+l is stored at natural position i=bitrev9(j) in buffer wr_sel.
- Write side:
  - in_ready = !full[wr_sel] && !clear.
  - A handshake (in_valid && in_ready) writes all lanes and increments wr_cnt (4-bit, wraps 15->0).
  - On the handshake with wr_cnt==15: set full[wr_sel], toggle wr_sel.
- Read side:
  - out_valid = full[rd_sel].
  - out_data = row rd_cnt of buffer rd_sel when out_valid, else 0. It is combinational from storage, so there are no added register stages.
  - out_last = out_valid && rd_cnt==15.
  - A handshake (out_valid && out_ready) increments rd_cnt.
  - On the rd_cnt==15 handshake: clear full[rd_sel], toggle rd_sel.
- Latency: first output beat is valid the cycle after the 16th input handshake.
- Throughput: one beat per cycle sustained on both sides. A second frame may be written while the first drains.
- Both full:
  - in_ready=0 until the final read handshake of the draining frame.
  - in_ready rises the cycle after that handshake. The one-cycle bubble is accepted.
- Simultaneous completion: a write-completion and a read-completion in the same cycle act on different buffers. Both take effect with no loss.
- Backpressure: out_data and out_last hold stable while out_valid && !out_ready.
- in_valid without in_ready is ignored; no data is written and no counter moves.
- clear: next cycle wr_cnt=rd_cnt=0, full=0, wr_sel=rd_sel=0, out_valid=0. Any handshake in the clear cycle is ignored. Takes priority over everything except reset_n.
- reset_n asserted mid-frame: immediate return to the reset state. The partial frame is lost.
- Widths: counters are 4 bits; bitrev9 is pure wiring; no arithmetic on data.

Decomposition:
- Shared package/defines:
  - DATA_SIZE_ARB, PE_NUMBER, DEPTH, LOG_N.
  - A bitrev9 function for the RTL and a matching one for the bench.
- Natural sub-module reorder_frame_buf, instantiated twice:
  - Holds one N-word register frame.
  - Write port: PE_NUMBER words at scattered bitrev9 addresses.
  - Read port: one natural-order row.
- The top level holds the counters, full flags, select bits and handshake logic.

Test Plan:
- Single frame, tagged data: after reset, drive beat b lane l = bitrev9(32b+l) for b=0..15 with out_ready=1 -> out_valid rises the cycle after the 16th beat; output beat r lane l = 32r+l; out_last on beat 15 only; spot checks: output beat 8 lane 0 = 256, beat 0 lane 1 = 1.
- Back-to-back frames: three frames, the second and third tagged +1000 and +2000, in_valid held high, out_ready=1 -> in_ready never drops; outputs are in natural order with matching tags; exactly 48 output beats.
- Backpressure: out_ready=0 while two frames are written -> in_ready=0 after 32 input beats. Raise out_ready -> in_ready returns 1 the cycle after the 16th output beat; out_data stays stable during the stall.
- Random stalls: random in_valid/out_ready at 50% over 20 frames -> scoreboard matches the natural-order model; no drop or duplication.
- clear mid-frame: assert clear after 7 input beats, then send a full fresh frame -> output is only the fresh frame, correctly ordered.
- Async reset mid-drain: pull reset_n low during output beat 5 -> out_valid=0, out_data=0, in_ready=1 immediately; the next frame is correct.
